gf_mul_iter: RTL and testbench
==============================

Name: gf_mul_iter

Overview:
- Iterative, handshaked multiplier over GF(2^BIT_WIDTH) in polynomial basis with a parametrised reduction polynomial.
- Generalises the combinational sub-field multipliers to arbitrary width, with a configurable digit size: DIGIT_WIDTH bits of in_b are consumed per cycle.
- Used for key-schedule/test-vector paths and area-constrained datapaths where one result per few cycles suffices.
- Valid/ready on both sides; supports back-to-back operation.

Parameters:
- BIT_WIDTH, 8, field width N; legal 1..16.
- POLY, 8'h1B, low N bits of the irreducible polynomial; x^N is implicit. Ignored when N=1.
- DIGIT_WIDTH, 1, multiplier bits processed per cycle; must divide BIT_WIDTH.
- Derived: ITER = BIT_WIDTH/DIGIT_WIDTH.

Ports:
- in_clock  input  1  clock
- in_reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- out_ready  output  1  block can accept operands
- in_a  input  BIT_WIDTH  multiplicand
- in_b  input  BIT_WIDTH  multiplier
- out_valid  output  1  result valid
- in_ready  input  1  downstream accepts result
- out_c  output  BIT_WIDTH  product a·b mod P

Behaviour:
- One clock (in_clock), reset synchronous and active-high (in_reset); all state updates on rising in_clock.
- Reset: state=IDLE, out_valid=0, out_c=0, accumulator=0, counter=0. out_ready forced 0 while in_reset=1. Reset mid-operation aborts the operation; no result is produced.
- FSM IDLE: out_ready=1. On in_valid & out_ready: latch a, latch b, clear acc, counter=0, go to BUSY.
- FSM BUSY: out_ready=0; inputs ignored. Each cycle applies a Horner step on the top DIGIT_WIDTH bits of the b register, MSB first. For each bit j, from high to low: acc = xtime(acc) ^ (bit_j ? a : 0). Then shift b left by DIGIT_WIDTH and increment the counter. After the ITER-th step, load out_c with the final acc, set out_valid=1, go to DONE.
- xtime(v) = (v<<1)[N-1:0] ^ (v[N-1] ? POLY : 0).
- FSM DONE: out_valid=1; out_c stable.
  - On in_ready=1: out_valid drops next cycle. out_ready=in_ready in this state.
  - If in_valid is also high in that cycle, new operands are accepted and the FSM goes straight to BUSY (back-to-back).
  - Otherwise the FSM goes to IDLE.
- Latency: operands accepted at edge k give out_valid=1 after edge k+ITER.
- Throughput: one result per ITER+1 cycles under continuous handshake.
- out_c holds the last result after the handshake until the next DONE; it is only meaningful while out_valid=1.
- in_valid while BUSY: ignored; upstream must hold its operands until it sees out_ready.
- in_ready while not DONE: ignored.
- Zero operand: result 0 after the full ITER cycles; there is no early termination.
- BIT_WIDTH=1: result is a & b, ITER=1.
- Elaboration errors ($error):
  - BIT_WIDTH % DIGIT_WIDTH != 0
  - BIT_WIDTH < 1
  - DIGIT_WIDTH < 1
  - BIT_WIDTH > 16

Decomposition:
- aes128_package gains:
  - gf_mul_state_t enum {IDLE, BUSY, DONE}
  - constant AES_POLY = 8'h1B
- Sub-module gf_mul_digit_step: purely combinational, parameters BIT_WIDTH/DIGIT_WIDTH/POLY; inputs acc, a, digit; output next acc (DIGIT_WIDTH chained xtime/xor stages).
- gf_mul_iter contains the FSM, the counter sized $clog2(ITER+1), the operand registers and the result register.

Test Plan:
- N=8, POLY=8'h1B, D=1: a=0x57, b=0x83 -> out_c=0xC1, out_valid rises exactly 8 cycles after acceptance. Also a=0x57, b=0x13 -> 0xFE.
- N=8, D=4: a=0x02, b=0x87 -> 0x15 after 2 cycles; a=0x00, b=0xFF -> 0x00 after 2 cycles.
- N=4, POLY=4'h3, D=2: a=0x2, b=0x9 -> 0x1. Sweep all 256 pairs against a software reference model.
- Back-to-back: in_valid and in_ready held at 1 with 3 operand pairs -> results in order, one per ITER+1 cycles, out_ready pulses only in IDLE/DONE cycles.
- Backpressure: in_ready=0 for 5 cycles in DONE -> out_c and out_valid stable, out_ready=0, extra in_valid ignored.
- Reset mid-BUSY: assert in_reset at step 3 of 8 -> next cycle out_valid=0, out_c=0, IDLE. A new a=0x57, b=0x83 then gives 0xC1.

Source files
------------

// File: rtl/gf_mul_iter_pkg.sv
// Shared types and constants for the iterative GF(2^N) multiplier.
package gf_mul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf_mul_state_t;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int MAX_BIT_WIDTH = 16;

endpackage

// File: rtl/gf_mul_digit_step.sv
// One Horner step over DIGIT_WIDTH multiplier bits, MSB first:
// acc = xtime(acc) ^ (bit ? a : 0), chained DIGIT_WIDTH times.
module gf_mul_digit_step
  import gf_mul_iter_pkg::*;
#(
  parameter int          BIT_WIDTH   = 8,
  parameter int          DIGIT_WIDTH = 1,
  parameter logic [15:0] POLY        = 16'(AES_POLY)
) (
  input  logic [BIT_WIDTH-1:0]   in_acc,
  input  logic [BIT_WIDTH-1:0]   in_a,
  input  logic [DIGIT_WIDTH-1:0] in_digit,
  output logic [BIT_WIDTH-1:0]   out_acc
);

  logic [BIT_WIDTH-1:0] w_acc;

  // For a 1-bit field the shift clears the value and the polynomial plays no part.
  function automatic logic [BIT_WIDTH-1:0] xtime(input logic [BIT_WIDTH-1:0] v);
    logic [BIT_WIDTH-1:0] r;
    r = v << 1;
    if (BIT_WIDTH > 1 && v[BIT_WIDTH-1]) r = r ^ POLY[BIT_WIDTH-1:0];
    return r;
  endfunction

  always_comb begin
    w_acc = in_acc;
    for (int j = DIGIT_WIDTH - 1; j >= 0; j--) begin
      w_acc = xtime(w_acc) ^ (in_digit[j] ? in_a : '0);
    end
  end

  assign out_acc = w_acc;

endmodule

// File: rtl/gf_mul_iter.sv
// Iterative GF(2^N) multiplier, DIGIT_WIDTH multiplier bits per cycle.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module gf_mul_iter
  import gf_mul_iter_pkg::*;
#(
  parameter int          BIT_WIDTH   = 8,
  parameter logic [15:0] POLY        = 16'(AES_POLY),
  parameter int          DIGIT_WIDTH = 1
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_valid,
  output logic                 out_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_c,
  output logic [1:0]           out_dbg_state
);

  // Guarded so an illegal DIGIT_WIDTH still elaborates far enough to report.
  localparam int ITER  = (DIGIT_WIDTH > 0 && DIGIT_WIDTH <= BIT_WIDTH) ?
                         BIT_WIDTH / DIGIT_WIDTH : 1;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  if (BIT_WIDTH < 1) begin : g_err_bw_min
    $error("gf_mul_iter: BIT_WIDTH must be >= 1");
  end
  if (BIT_WIDTH > MAX_BIT_WIDTH) begin : g_err_bw_max
    $error("gf_mul_iter: BIT_WIDTH must be <= 16");
  end
  if (DIGIT_WIDTH < 1) begin : g_err_dw_min
    $error("gf_mul_iter: DIGIT_WIDTH must be >= 1");
  end else if (BIT_WIDTH % DIGIT_WIDTH != 0) begin : g_err_dw_div
    $error("gf_mul_iter: DIGIT_WIDTH must divide BIT_WIDTH");
  end

  gf_mul_state_t        r_state;
  gf_mul_state_t        w_next;
  logic [BIT_WIDTH-1:0] r_a;
  logic [BIT_WIDTH-1:0] r_b;
  logic [BIT_WIDTH-1:0] r_acc;
  logic [BIT_WIDTH-1:0] r_c;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_WIDTH-1:0] w_step;
  logic                 w_accept;
  logic                 w_last;

  gf_mul_digit_step #(
    .BIT_WIDTH  (BIT_WIDTH),
    .DIGIT_WIDTH(DIGIT_WIDTH),
    .POLY       (POLY)
  ) u_step (
    .in_acc  (r_acc),
    .in_a    (r_a),
    .in_digit(r_b[BIT_WIDTH-1 -: DIGIT_WIDTH]),
    .out_acc (w_step)
  );

  assign w_accept      = in_valid & out_ready;
  assign w_last        = (r_cnt == LAST);
  assign out_c         = r_c;
  assign out_dbg_state = r_state;

  always_ff @(posedge in_clock) begin
    if (in_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    out_ready = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        out_ready = ~in_reset;
        if (w_accept) w_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_ready = in_ready & ~in_reset;
        if (in_ready) w_next = w_accept ? BUSY : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_c   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_acc <= w_step;
      r_b   <= r_b << DIGIT_WIDTH;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_c <= w_step;
    end
  end

endmodule

// File: tb/tb_gf_mul_iter.sv
// Bench for gf_mul_iter: three configurations (N8/D1, N8/D4, N4/D2), queued expectations
// popped by per-instance monitors on each output handshake.
module tb_gf_mul_iter;
  import gf_mul_iter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // N=8, POLY=0x1B, D=1
  logic       a_iv, a_rdy, a_ov, a_ir;
  logic [7:0] a_a, a_b, a_c;
  logic [1:0] a_st;
  // N=8, POLY=0x1B, D=4
  logic       b_iv, b_rdy, b_ov, b_ir;
  logic [7:0] b_a, b_b, b_c;
  logic [1:0] b_st;
  // N=4, POLY=0x3, D=2
  logic       c_iv, c_rdy, c_ov, c_ir;
  logic [3:0] c_a, c_b, c_c;
  logic [1:0] c_st;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [3:0] exp_c[$];

  gf_mul_iter #(.BIT_WIDTH(8), .POLY(16'h001B), .DIGIT_WIDTH(1)) u_a (
    .in_clock(clk), .in_reset(rst), .in_valid(a_iv), .out_ready(a_rdy),
    .in_a(a_a), .in_b(a_b), .out_valid(a_ov), .in_ready(a_ir), .out_c(a_c),
    .out_dbg_state(a_st));

  gf_mul_iter #(.BIT_WIDTH(8), .POLY(16'h001B), .DIGIT_WIDTH(4)) u_b (
    .in_clock(clk), .in_reset(rst), .in_valid(b_iv), .out_ready(b_rdy),
    .in_a(b_a), .in_b(b_b), .out_valid(b_ov), .in_ready(b_ir), .out_c(b_c),
    .out_dbg_state(b_st));

  gf_mul_iter #(.BIT_WIDTH(4), .POLY(16'h0003), .DIGIT_WIDTH(2)) u_c (
    .in_clock(clk), .in_reset(rst), .in_valid(c_iv), .out_ready(c_rdy),
    .in_a(c_a), .in_b(c_b), .out_valid(c_ov), .in_ready(c_ir), .out_c(c_c),
    .out_dbg_state(c_st));

  // Reference: LSB-first shift-and-add with reduction of the shifted multiplicand.
  function automatic int ref_mul(input int x, input int y, input int n, input int poly);
    int p = 0;
    int mask = (1 << n) - 1;
    int xv = x;
    for (int i = 0; i < n; i++) begin
      if (((y >> i) & 1) != 0) p = p ^ xv;
      if (((xv >> (n - 1)) & 1) != 0) xv = ((xv << 1) & mask) ^ poly;
      else                            xv = (xv << 1) & mask;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int u);
    case (u)
      0:       return a_rdy;
      1:       return b_rdy;
      default: return c_rdy;
    endcase
  endfunction

  function automatic logic ov_of(input int u);
    case (u)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  // Present operands, wait (bounded) for out_ready, transfer on the next edge.
  task automatic send(input int u, input int x, input int y, input int e, input bit push);
    int n = 0;
    case (u)
      0:       begin a_a = x[7:0]; a_b = y[7:0]; a_iv = 1'b1; end
      1:       begin b_a = x[7:0]; b_b = y[7:0]; b_iv = 1'b1; end
      default: begin c_a = x[3:0]; c_b = y[3:0]; c_iv = 1'b1; end
    endcase
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_of(u) && n < 50);
    if (!rdy_of(u)) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (push) begin
      case (u)
        0:       exp_a.push_back(e[7:0]);
        1:       exp_b.push_back(e[7:0]);
        default: exp_c.push_back(e[3:0]);
      endcase
    end
    @(posedge clk);
    #1;
    case (u)
      0:       a_iv = 1'b0;
      1:       b_iv = 1'b0;
      default: c_iv = 1'b0;
    endcase
  endtask

  // Called right after send(): counts edges until out_valid appears.
  task automatic wait_valid(input int u, input int exp_lat, input string name);
    int n = 0;
    while (!ov_of(u) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, exp_lat);
  endtask

  always @(negedge clk) begin
    if (!rst && a_ov && a_ir) begin
      if (exp_a.size() == 0) check("a_unexpected_out", a_c, 32'hFFFF_FFFF);
      else                   check("a_result", a_c, exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && b_ov && b_ir) begin
      if (exp_b.size() == 0) check("b_unexpected_out", b_c, 32'hFFFF_FFFF);
      else                   check("b_result", b_c, exp_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && c_ov && c_ir) begin
      if (exp_c.size() == 0) check("c_unexpected_out", c_c, 32'hFFFF_FFFF);
      else                   check("c_result", c_c, exp_c.pop_front());
    end
  end

  initial begin
    logic [7:0] bp_a[3];
    logic [7:0] bp_b[3];
    logic [7:0] bp_r[3];
    int acc_at[3];
    int idx, cyc_n, rdy_cnt, n;
    bit took, saw_valid;

    rst = 1'b1;
    a_iv = 0; a_ir = 0; a_a = 0; a_b = 0;
    b_iv = 0; b_ir = 0; b_a = 0; b_b = 0;
    c_iv = 0; c_ir = 0; c_a = 0; c_b = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", a_ov, 0);
    check("rst_a_c", a_c, 0);
    check("rst_a_ready", a_rdy, 0);
    check("rst_a_state", a_st, IDLE);
    check("rst_b_ready", b_rdy, 0);
    check("rst_c_valid", c_ov, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_a_ready", a_rdy, 1);
    @(posedge clk);
    #1;

    // N8/D1 directed vectors and latency
    a_ir = 1'b1;
    send(0, 8'h57, 8'h83, 8'hC1, 1);
    wait_valid(0, 8, "lat_a_57x83");
    send(0, 8'h57, 8'h13, 8'hFE, 1);
    wait_valid(0, 8, "lat_a_57x13");
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: result held, extra in_valid ignored
    a_ir = 1'b0;
    send(0, 8'h53, 8'hCA, 8'h01, 1);
    wait_valid(0, 8, "lat_a_bp");
    a_a = 8'h11; a_b = 8'h22; a_iv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", a_ov, 1);
      check("bp_c", a_c, 8'h01);
      check("bp_ready", a_rdy, 0);
    end
    @(posedge clk);
    #1;
    a_iv = 1'b0;
    a_ir = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_accept_valid", a_ov, 0);
    check("bp_no_accept_state", a_st, IDLE);

    // Back-to-back with in_valid/in_ready held high
    bp_a[0] = 8'h57; bp_b[0] = 8'h83; bp_r[0] = 8'hC1;
    bp_a[1] = 8'h02; bp_b[1] = 8'h87; bp_r[1] = 8'h15;
    bp_a[2] = 8'h53; bp_b[2] = 8'hCA; bp_r[2] = 8'h01;
    idx = 0; cyc_n = 0; rdy_cnt = 0;
    a_a = bp_a[0]; a_b = bp_b[0]; a_iv = 1'b1;
    while (idx < 3 && cyc_n < 100) begin
      @(negedge clk);
      cyc_n++;
      took = a_rdy;
      if (took) begin
        rdy_cnt++;
        exp_a.push_back(bp_r[idx]);
        acc_at[idx] = cyc_n;
      end
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 3) begin a_a = bp_a[idx]; a_b = bp_b[idx]; end
        else           a_iv = 1'b0;
      end
    end
    a_iv = 1'b0;
    check("b2b_accepted", idx, 3);
    check("b2b_gap1", acc_at[1] - acc_at[0], 9);
    check("b2b_gap2", acc_at[2] - acc_at[1], 9);
    check("b2b_ready_cycles", rdy_cnt, 3);
    repeat (12) @(posedge clk);
    #1;

    // Reset during BUSY at step 3 of 8
    send(0, 8'h11, 8'h22, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", a_ov, 0);
    check("mid_rst_c", a_c, 0);
    check("mid_rst_ready", a_rdy, 0);
    check("mid_rst_state", a_st, IDLE);
    rst = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_ov) saw_valid = 1;
    end
    check("mid_rst_no_result", saw_valid, 0);
    check("mid_rst_ready_after", a_rdy, 1);
    @(posedge clk);
    #1;
    send(0, 8'h57, 8'h83, 8'hC1, 1);
    wait_valid(0, 8, "lat_a_after_rst");

    // N8/D4
    b_ir = 1'b1;
    send(1, 8'h02, 8'h87, 8'h15, 1);
    wait_valid(1, 2, "lat_b_02x87");
    send(1, 8'h00, 8'hFF, 8'h00, 1);
    wait_valid(1, 2, "lat_b_00xFF");
    send(1, 8'h57, 8'h83, 8'hC1, 1);
    wait_valid(1, 2, "lat_b_57x83");

    // N4/D2: hand vector, then all 256 pairs
    c_ir = 1'b1;
    send(2, 2, 9, 1, 1);
    wait_valid(2, 2, "lat_c_2x9");
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        send(2, x, y, ref_mul(x, y, 4, 3), 1);
      end
    end

    n = 0;
    while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", exp_a.size() + exp_b.size() + exp_c.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
